// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

   localparam int          DEFAULT_MEM_DEPTH = 256;
   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [5:0]  HALT_OPCODE       = 6'h3F;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: control from decode/execute, the FD pipeline register,
// debug visibility of PC/state, and a write port used to preload instruction storage.
interface instruction_fetch_if #(
   parameter int MEM_DEPTH = instruction_fetch_pkg::DEFAULT_MEM_DEPTH
);
   import instruction_fetch_pkg::*;

   localparam int AW = $clog2(MEM_DEPTH);

   // Flow control: there is no ready signal. Stall high (without a redirect) holds the FD
   // register and the PC; FD_Valid qualifies FD_IR and is low for bubbles, redirects and HALT.
   logic               Stall;
   logic               Branch_Taken;
   logic [31:0]        Branch_Target;
   logic               Jump;
   logic [31:0]        JAddr;
   logic [31:0]        FD_PC;
   logic [31:0]        FD_IR;
   logic               FD_Valid;
   logic               Halted;
   logic [31:0]        Dbg_PC;
   fetch_state_e       Dbg_State;
   logic               Load_En;
   logic [AW-1:0]      Load_Addr;
   logic [31:0]        Load_Data;

   modport master (
      output Stall, Branch_Taken, Branch_Target, Jump, JAddr,
      output Load_En, Load_Addr, Load_Data,
      input  FD_PC, FD_IR, FD_Valid, Halted, Dbg_PC, Dbg_State
   );

   modport slave (
      input  Stall, Branch_Taken, Branch_Target, Jump, JAddr,
      input  Load_En, Load_Addr, Load_Data,
      output FD_PC, FD_IR, FD_Valid, Halted, Dbg_PC, Dbg_State
   );

endinterface

// File: rtl/instruction_fetch_inst_rom.sv
// Instruction storage: combinational read, plus a clocked write port for preloading.
// Contents are never reset.
module inst_rom #(
   parameter int MEM_DEPTH = instruction_fetch_pkg::DEFAULT_MEM_DEPTH,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [31:0]   data,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data
);

   logic [31:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign data = mem[addr];

endmodule

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: PC register, RUN/HALT FSM and the FD pipeline register.
// Redirects (branch beats jump) win over stall and are the only way out of HALT.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int          MEM_DEPTH = DEFAULT_MEM_DEPTH,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   instruction_fetch_if.slave bus
);

   localparam int AW = $clog2(MEM_DEPTH);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fd_pc_q, fd_pc_d;
   logic [31:0]  fd_ir_q, fd_ir_d;
   logic         fd_valid_q, fd_valid_d;
   logic         halted_q, halted_d;

   logic [31:0]  rom_data;
   logic [31:0]  redirect_target;
   logic         redirect;
   logic         fetch_is_halt;

   // Upper PC bits are not decoded, so the memory aliases across the address space.
   inst_rom #(.MEM_DEPTH(MEM_DEPTH)) u_rom (
      .clk       (clk),
      .addr      (pc_q[AW+1:2]),
      .data      (rom_data),
      .load_en   (bus.Load_En),
      .load_addr (bus.Load_Addr),
      .load_data (bus.Load_Data)
   );

   assign redirect        = bus.Branch_Taken | bus.Jump;
   assign redirect_target = bus.Branch_Taken ? bus.Branch_Target : bus.JAddr;
   assign fetch_is_halt   = (rom_data[31:26] == HALT_OPCODE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fd_pc_d    = fd_pc_q;
      fd_ir_d    = fd_ir_q;
      fd_valid_d = fd_valid_q;
      if (redirect) begin
         pc_d       = redirect_target & ~32'h3;
         fd_pc_d    = 32'h0;
         fd_ir_d    = NOP_WORD;
         fd_valid_d = 1'b0;
         state_d    = ST_RUN;
      end else if (!bus.Stall) begin
         if (state_q == ST_HALT || fetch_is_halt) begin
            // The HALT word itself is squashed; PC stays pointing at it.
            fd_ir_d    = NOP_WORD;
            fd_valid_d = 1'b0;
            state_d    = ST_HALT;
         end else begin
            fd_ir_d    = rom_data;
            fd_pc_d    = pc_q + 32'd4;
            fd_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
         end
      end
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         fd_pc_q    <= 32'h0;
         fd_ir_q    <= NOP_WORD;
         fd_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fd_pc_q    <= fd_pc_d;
         fd_ir_q    <= fd_ir_d;
         fd_valid_q <= fd_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.FD_PC     = fd_pc_q;
   assign bus.FD_IR     = fd_ir_q;
   assign bus.FD_Valid  = fd_valid_q;
   assign bus.Halted    = halted_q;
   assign bus.Dbg_PC    = pc_q;
   assign bus.Dbg_State = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written HALT/reset sequences,
// and a randomized run against a behavioural model of the fetch rules.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_ir, m_fdpc;
   logic        m_valid, m_halt;

   typedef struct {
      logic        st;
      logic        bt;
      logic [31:0] btgt;
      logic        j;
      logic [31:0] ja;
      logic [31:0] e_ir;
      logic [31:0] e_fdpc;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl [19];

   instruction_fetch_if #(.MEM_DEPTH(DEPTH)) bus ();

   instruction_fetch #(.MEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [31:0] fw(input int i);
      return 32'h2000_0000 | i;
   endfunction

   function automatic vec_t mk(input logic st, input logic bt, input logic [31:0] btgt,
                               input logic j, input logic [31:0] ja, input logic [31:0] ir,
                               input logic [31:0] fdpc, input logic v, input logic [31:0] pc);
      vec_t r;
      r.st = st; r.bt = bt; r.btgt = btgt; r.j = j; r.ja = ja;
      r.e_ir = ir; r.e_fdpc = fdpc; r.e_valid = v; r.e_pc = pc;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic st, input logic bt, input logic [31:0] btgt,
                         input logic j, input logic [31:0] ja);
      bus.Stall = st; bus.Branch_Taken = bt; bus.Branch_Target = btgt;
      bus.Jump = j; bus.JAddr = ja;
   endtask

   task automatic load_word(input int a, input logic [31:0] w);
      bus.Load_En = 1'b1; bus.Load_Addr = a[7:0]; bus.Load_Data = w;
      tick();
      bus.Load_En = 1'b0;
      m_mem[a] = w;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " rst ir"},     bus.FD_IR, NOP_WORD);
      check({tag, " rst fd_pc"},  bus.FD_PC, 32'h0);
      check({tag, " rst valid"},  {31'h0, bus.FD_Valid}, 32'h0);
      check({tag, " rst halted"}, {31'h0, bus.Halted}, 32'h0);
      check({tag, " rst pc"},     bus.Dbg_PC, 32'h0);
   endtask

   // Called between edges: reset acts without waiting for a clock.
   task automatic enter_reset(input string tag);
      rst = 1'b0;
      #1;
      check_reset_outs(tag);
   endtask

   task automatic leave_reset();
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] ir, input logic [31:0] fdpc,
                             input logic v, input logic h, input logic [31:0] pc);
      check({tag, " ir"},     bus.FD_IR, ir);
      check({tag, " fd_pc"},  bus.FD_PC, fdpc);
      check({tag, " valid"},  {31'h0, bus.FD_Valid}, {31'h0, v});
      check({tag, " halted"}, {31'h0, bus.Halted}, {31'h0, h});
      check({tag, " pc"},     bus.Dbg_PC, pc);
   endtask

   // ---------------- reference model ----------------
   task automatic model_step(input logic st, input logic bt, input logic [31:0] btgt,
                             input logic j, input logic [31:0] ja);
      logic [31:0] w;
      if (bt || j) begin
         m_pc    = (bt ? btgt : ja) & 32'hFFFF_FFFC;
         m_ir    = 32'h0;
         m_valid = 1'b0;
         m_fdpc  = 32'h0;
         m_halt  = 1'b0;
      end else if (!st) begin
         w = m_mem[(m_pc / 4) % DEPTH];
         if (m_halt || w[31:26] == 6'h3F) begin
            m_ir    = 32'h0;
            m_valid = 1'b0;
            m_halt  = 1'b1;
         end else begin
            m_ir    = w;
            m_fdpc  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end
      end
   endtask

   // ---------------- test ----------------
   initial begin
      logic        st, bt, j;
      logic [31:0] btgt, ja, w;

      tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20010005, 32'h4,   1'b1, 32'h4);
      tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20020003, 32'h8,   1'b1, 32'h8);
      tbl[2]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20020003, 32'h8,   1'b1, 32'h8);
      tbl[3]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20020003, 32'h8,   1'b1, 32'h8);
      tbl[4]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20020003, 32'h8,   1'b1, 32'h8);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h00221820, 32'hC,   1'b1, 32'hC);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h40,        32'h0,        32'h0,   1'b0, 32'h40);
      tbl[7]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         fw(16),       32'h44,  1'b1, 32'h44);
      tbl[8]  = mk(1'b0, 1'b1, 32'h20,  1'b1, 32'h80,        32'h0,        32'h0,   1'b0, 32'h20);
      tbl[9]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         fw(8),        32'h24,  1'b1, 32'h24);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h43,        32'h0,        32'h0,   1'b0, 32'h40);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         fw(16),       32'h44,  1'b1, 32'h44);
      tbl[12] = mk(1'b0, 1'b1, 32'h408, 1'b0, 32'h0,         32'h0,        32'h0,   1'b0, 32'h408);
      tbl[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h00221820, 32'h40C, 1'b1, 32'h40C);
      tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'h0,        32'h0,   1'b0, 32'hFFFF_FFFC);
      tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         fw(255),      32'h0,   1'b1, 32'h0);
      tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h20010005, 32'h4,   1'b1, 32'h4);
      tbl[17] = mk(1'b1, 1'b1, 32'h10,  1'b0, 32'h0,         32'h0,        32'h0,   1'b0, 32'h10);
      tbl[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         fw(4),        32'h14,  1'b1, 32'h14);

      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      bus.Load_En = 1'b0; bus.Load_Addr = '0; bus.Load_Data = 32'h0;

      // Reset at power-up, before any clock edge.
      #2;
      enter_reset("init");
      for (int i = 0; i < DEPTH; i++) load_word(i, fw(i));
      load_word(0, 32'h20010005);
      load_word(1, 32'h20020003);
      load_word(2, 32'h00221820);
      leave_reset();

      // Vector table: sequential fetch, stall, jump-over-stall, branch-beats-jump,
      // unaligned target, aliasing, PC wrap, redirect over stall.
      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].st, tbl[i].bt, tbl[i].btgt, tbl[i].j, tbl[i].ja);
         tick();
         check_outs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_fdpc, tbl[i].e_valid,
                    1'b0, tbl[i].e_pc);
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      // HALT: fetch of an opcode-3F word parks the unit; only a redirect leaves.
      enter_reset("halt");
      load_word(3, 32'hFC00_0000);
      leave_reset();
      tick(); tick(); tick();
      check_outs("pre_halt", 32'h00221820, 32'hC, 1'b1, 1'b0, 32'hC);
      tick();
      check_outs("halt_entry", 32'h0, 32'hC, 1'b0, 1'b1, 32'hC);
      for (int i = 0; i < 10; i++) begin
         set_in(i[0], 1'b0, 32'h0, 1'b0, 32'h0);
         tick();
         check({$sformatf("halt_hold%0d", i), " halted"}, {31'h0, bus.Halted}, 32'h1);
         check({$sformatf("halt_hold%0d", i), " valid"},  {31'h0, bus.FD_Valid}, 32'h0);
         check({$sformatf("halt_hold%0d", i), " pc"},     bus.Dbg_PC, 32'hC);
      end
      set_in(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      tick();
      check_outs("halt_exit", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_outs("halt_refetch", 32'h20010005, 32'h4, 1'b1, 1'b0, 32'h4);

      // Mid-stream reset with stall and redirect active: they are discarded.
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      enter_reset("mid");
      tick();
      check("mid_rst_hold pc", bus.Dbg_PC, 32'h0);
      check("mid_rst_hold valid", {31'h0, bus.FD_Valid}, 32'h0);
      leave_reset();
      tick();
      check_outs("mid_restart", 32'h20010005, 32'h4, 1'b1, 1'b0, 32'h4);

      // Randomized run against the behavioural model, with random contents including HALT words.
      enter_reset("rand");
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
         else if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
         load_word(i, w);
      end
      leave_reset();
      m_pc = 32'h0; m_ir = 32'h0; m_fdpc = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
      for (int n = 0; n < 600; n++) begin
         st   = ($urandom_range(0, 3) == 0);
         bt   = ($urandom_range(0, 15) == 0);
         j    = ($urandom_range(0, 15) == 0);
         btgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047));
         ja   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047));
         set_in(st, bt, btgt, j, ja);
         tick();
         model_step(st, bt, btgt, j, ja);
         check($sformatf("rand%0d ir", n),     bus.FD_IR, m_ir);
         check($sformatf("rand%0d valid", n),  {31'h0, bus.FD_Valid}, {31'h0, m_valid});
         check($sformatf("rand%0d halted", n), {31'h0, bus.Halted}, {31'h0, m_halt});
         check($sformatf("rand%0d pc", n),     bus.Dbg_PC, m_pc);
         if (m_valid) check($sformatf("rand%0d fd_pc", n), bus.FD_PC, m_fdpc);
      end

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
